alu_divider: RTL and testbench

//   Multi-cycle integer divider for the ALU; the inverse of the ripple adder datapath.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/div_step.sv | 23 ++
 rtl/alu_divider.sv | 144 ++++++++++++++
 tb/tb_alu_divider.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU divider.
package alu_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, compare, subtract.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_nxt,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           geq;

    // rem[WIDTH] set would mean the shifted value exceeds any divisor
    assign shifted = {rem[WIDTH-1:0], dvd_msb};
    assign diff    = shifted - {1'b0, divisor};
    assign geq     = rem[WIDTH] | (shifted >= {1'b0, divisor});
    assign rem_nxt = geq ? diff : shifted;
    assign q_bit   = geq;

endmodule

// File: rtl/alu_divider.sv
// RISC-V DIV/DIVU/REM/REMU restoring divider, one quotient bit per cycle.
module alu_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] res_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_S = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state;
    div_op_t          op;
    logic             sgn_q;
    logic             rsel_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   rem;
    logic [CW-1:0]    cnt;
    logic             q_neg;
    logic             r_neg;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             div0;
    logic             ovf;
    logic [WIDTH:0]   rem_nxt;
    logic             q_bit;

    assign op    = div_op_t'(op_i);
    assign a_neg = sgn_q & a_q[WIDTH-1];
    assign b_neg = sgn_q & b_q[WIDTH-1];
    // MIN_SIGNED negates to itself, which is its correct unsigned magnitude
    assign a_abs = a_neg ? -a_q : a_q;
    assign b_abs = b_neg ? -b_q : b_q;
    assign div0  = (b_q == '0);
    assign ovf   = sgn_q && (a_q == MIN_S) && (b_q == '1);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .dvd_msb (dvd[WIDTH-1]),
        .divisor (dvs),
        .rem_nxt (rem_nxt),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            res_valid_o <= 1'b0;
            res_o       <= '0;
            sgn_q       <= 1'b0;
            rsel_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            cnt         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        sgn_q       <= (op == DIV) || (op == REM);
                        rsel_q      <= (op == REM) || (op == REMU);
                        a_q         <= a_i;
                        b_q         <= b_i;
                        req_ready_o <= 1'b0;
                        state       <= PREP;
                    end
                end
                PREP: begin
                    if (div0) begin
                        res_o       <= rsel_q ? a_q : '1;
                        res_valid_o <= 1'b1;
                        state       <= DONE;
                    end else if (ovf) begin
                        res_o       <= rsel_q ? '0 : a_q;
                        res_valid_o <= 1'b1;
                        state       <= DONE;
                    end else begin
                        dvd   <= a_abs;
                        dvs   <= b_abs;
                        rem   <= '0;
                        cnt   <= LAST;
                        q_neg <= a_neg ^ b_neg;
                        r_neg <= a_neg;
                        state <= CALC;
                    end
                end
                CALC: begin
                    // dvd doubles as the quotient: bits shift out top, in bottom
                    rem <= rem_nxt;
                    dvd <= {dvd[WIDTH-2:0], q_bit};
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                FIX: begin
                    if (rsel_q) begin
                        res_o <= r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                    end else begin
                        res_o <= q_neg ? -dvd : dvd;
                    end
                    res_valid_o <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (res_ready_i) begin
                        res_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    req_ready_o <= 1'b1;
                    res_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_divider.sv
// Directed self-checking bench for alu_divider at WIDTH=32.
module tb_alu_divider;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res;

    int npass = 0;
    int ntotal = 0;

    logic [31:0] r;
    int          lat;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    alu_divider #(.WIDTH(32)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .op_i        (op),
        .a_i         (a),
        .b_i         (b),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_o       (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Issue one request; lat counts cycles with the accept cycle as T
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input bit take,
                          output logic [31:0] result, output int cycles);
        @(negedge clk);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        op = 2'b00;
        a = '0;
        b = '0;
        cycles = 1;
        while (!res_valid && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        result = res;
        if (take) begin
            res_ready = 1'b1;
            @(posedge clk);
            #1;
            res_ready = 1'b0;
        end
    endtask

    initial begin
        rstn = 1'b0;
        req_valid = 1'b0;
        res_ready = 1'b0;
        op = 2'b00;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res", res, 32'd0);
        rstn = 1'b1;

        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1'b1, r, lat);
        chk("divu_100_7", r, 32'd14);
        chk("divu_100_7_lat", lat, 32'd35);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 1'b1, r, lat);
        chk("remu_100_7", r, 32'd2);
        chk("remu_100_7_lat", lat, 32'd35);

        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, r, lat);
        chk("div_m7_2", r, 32'hFFFF_FFFD);
        run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 1'b1, r, lat);
        chk("rem_m7_2", r, 32'hFFFF_FFFF);
        run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 1'b1, r, lat);
        chk("rem_7_m2", r, 32'd1);

        run_op("div_5_0", OP_DIV, 32'd5, 32'd0, 1'b1, r, lat);
        chk("div_5_0", r, 32'hFFFF_FFFF);
        chk("div_5_0_lat", lat, 32'd2);
        run_op("rem_5_0", OP_REM, 32'd5, 32'd0, 1'b1, r, lat);
        chk("rem_5_0", r, 32'd5);
        chk("rem_5_0_lat", lat, 32'd2);
        run_op("divu_0_0", OP_DIVU, 32'd0, 32'd0, 1'b1, r, lat);
        chk("divu_0_0", r, 32'hFFFF_FFFF);
        chk("divu_0_0_lat", lat, 32'd2);

        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, r, lat);
        chk("div_ovf", r, 32'h8000_0000);
        chk("div_ovf_lat", lat, 32'd2);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, r, lat);
        chk("rem_ovf", r, 32'd0);
        run_op("divu_min", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, r, lat);
        chk("divu_min", r, 32'd0);
        chk("divu_min_lat", lat, 32'd35);
        run_op("div_min_2", OP_DIV, 32'h8000_0000, 32'd2, 1'b1, r, lat);
        chk("div_min_2", r, 32'hC000_0000);

        run_op("div_100_m7", OP_DIV, 32'd100, 32'hFFFF_FFF9, 1'b0, r, lat);
        chk("div_100_m7", r, 32'hFFFF_FFF2);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", {31'd0, res_valid}, 32'd1);
            chk("hold_res", res, 32'hFFFF_FFF2);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk("release_valid", {31'd0, res_valid}, 32'd0);
        chk("release_req_ready", {31'd0, req_ready}, 32'd1);
        run_op("b2b_remu", OP_REMU, 32'd100, 32'd7, 1'b1, r, lat);
        chk("b2b_remu", r, 32'd2);
        chk("b2b_remu_lat", lat, 32'd35);

        @(negedge clk);
        req_valid = 1'b1;
        op = OP_DIVU;
        a = 32'd12345;
        b = 32'd1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("midrst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_res", res, 32'd0);
        run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 1'b1, r, lat);
        chk("divu_9_3", r, 32'd3);
        chk("divu_9_3_lat", lat, 32'd35);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
